// File: rtl/tinker_pkg.sv
// Shared opcode encodings, core state type and instruction field helpers
// for the sequential Tinker integer core.
package tinker_pkg;

    localparam logic [4:0] OP_AND    = 5'b00000;
    localparam logic [4:0] OP_OR     = 5'b00001;
    localparam logic [4:0] OP_XOR    = 5'b00010;
    localparam logic [4:0] OP_NOT    = 5'b00011;
    localparam logic [4:0] OP_SHFTR  = 5'b00100;
    localparam logic [4:0] OP_SHFTRI = 5'b00101;
    localparam logic [4:0] OP_SHFTL  = 5'b00110;
    localparam logic [4:0] OP_SHFTLI = 5'b00111;
    localparam logic [4:0] OP_MOV    = 5'b10001;
    localparam logic [4:0] OP_MOVL   = 5'b10010;
    localparam logic [4:0] OP_ADD    = 5'b11000;
    localparam logic [4:0] OP_ADDI   = 5'b11001;
    localparam logic [4:0] OP_SUB    = 5'b11010;
    localparam logic [4:0] OP_SUBI   = 5'b11011;
    localparam logic [4:0] OP_MUL    = 5'b11100;
    localparam logic [4:0] OP_DIV    = 5'b11101;

    typedef enum logic {
        IDLE     = 1'b0,
        DIV_BUSY = 1'b1
    } state_t;

    function automatic logic [4:0] f_op(input logic [31:0] ins);
        return ins[31:27];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] ins);
        return ins[26:22];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] ins);
        return ins[21:17];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] ins);
        return ins[16:12];
    endfunction

    function automatic logic [11:0] f_lit(input logic [31:0] ins);
        return ins[11:0];
    endfunction

    // FP opcodes (10100..10111) deliberately fall into the default branch.
    function automatic logic op_is_legal(input logic [4:0] op);
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHFTR, OP_SHFTRI, OP_SHFTL, OP_SHFTLI,
            OP_MOV, OP_MOVL, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_DIV:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tinker_divider.sv
// Unsigned restoring divider, one quotient bit per cycle over DATA_W cycles.
// The first step runs on the start edge, so done pulses DATA_W-1 cycles later.
module tinker_divider #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient
);

    localparam int CW = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]     cnt_q;
    logic              busy_q, done_q;

    logic [DATA_W-1:0] rem_in, quo_in, dvs_in, rem_d, quo_d;
    logic [DATA_W:0]   trial;
    logic              fits;

    // A zero divisor always "fits", which yields the all-ones quotient.
    always_comb begin
        rem_in = start ? '0 : rem_q;
        quo_in = start ? dividend : quo_q;
        dvs_in = start ? divisor : dvs_q;
        trial  = {rem_in, quo_in[DATA_W-1]};
        fits   = trial >= {1'b0, dvs_in};
        rem_d  = fits ? (trial[DATA_W-1:0] - dvs_in) : trial[DATA_W-1:0];
        quo_d  = {quo_in[DATA_W-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q  <= rem_d;
                quo_q  <= quo_d;
                dvs_q  <= dvs_in;
                cnt_q  <= CW'(DATA_W - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/tinker_seq_core.sv
// Clocked Tinker integer core: one instruction per valid/ready transfer,
// single-cycle ALU ops plus a multi-cycle unsigned DIV.
module tinker_seq_core
    import tinker_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    output logic              done,
    output logic              illegal,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    // Handshake: a transfer happens on a rising edge where in_valid && in_ready;
    // in_ready depends on state only, so the source must hold the instruction while it is low.

    localparam int         SH_W  = $clog2(DATA_W);
    localparam int         AW    = $clog2(NUM_REGS);
    localparam logic [5:0] NREGS = 6'(NUM_REGS);

    logic [DATA_W-1:0] reg_file [NUM_REGS];

    state_t     state_q;
    logic       done_q, illegal_q;
    logic [4:0] div_rd_q;

    logic [4:0]        op, rd, rs, rt;
    logic [11:0]       lit12;
    logic [DATA_W-1:0] lit, op1, op2, alu_res;
    logic [SH_W-1:0]   sh_amt;
    logic              imm_op, bad, accept, div_start;
    logic              we;
    logic [4:0]        waddr;
    logic [DATA_W-1:0] wdata;
    logic              div_busy, div_done;
    logic [DATA_W-1:0] div_quot;

    function automatic logic in_range(input logic [4:0] idx);
        return {1'b0, idx} < NREGS;
    endfunction

    function automatic logic [DATA_W-1:0] rf_read(input logic [4:0] idx);
        if (in_range(idx)) return reg_file[idx[AW-1:0]];
        return '0;
    endfunction

    always_comb begin
        op     = f_op(instruction);
        rd     = f_rd(instruction);
        rs     = f_rs(instruction);
        rt     = f_rt(instruction);
        lit12  = f_lit(instruction);
        lit    = {{(DATA_W-12){lit12[11]}}, lit12};
        imm_op = (op == OP_SHFTRI) || (op == OP_SHFTLI) || (op == OP_ADDI) || (op == OP_SUBI);
        op1    = rf_read(imm_op ? rd : rs);
        op2    = (imm_op || op == OP_MOVL) ? lit : rf_read(rt);
        sh_amt = op2[SH_W-1:0];
        alu_res = '0;
        case (op)
            OP_AND:                alu_res = op1 & op2;
            OP_OR:                 alu_res = op1 | op2;
            OP_XOR:                alu_res = op1 ^ op2;
            OP_NOT:                alu_res = ~op1;
            OP_SHFTR, OP_SHFTRI:   alu_res = op1 >> sh_amt;
            OP_SHFTL, OP_SHFTLI:   alu_res = op1 << sh_amt;
            OP_MOV:                alu_res = op1;
            OP_MOVL:               alu_res = op2;
            OP_ADD, OP_ADDI:       alu_res = op1 + op2;
            OP_SUB, OP_SUBI:       alu_res = op1 - op2;
            OP_MUL:                alu_res = op1 * op2;
            default:               alu_res = '0;
        endcase
        bad       = !op_is_legal(op) || !in_range(rd) || !in_range(rs) || !in_range(rt);
        accept    = in_valid && in_ready;
        div_start = accept && !bad && (op == OP_DIV);
    end

    // The single write port is shared: the DIV result owns it only while busy.
    always_comb begin
        we    = 1'b0;
        waddr = rd;
        wdata = alu_res;
        if (state_q == DIV_BUSY) begin
            we    = div_done && !div_busy;
            waddr = div_rd_q;
            wdata = div_quot;
        end else if (accept && !bad && (op != OP_DIV)) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) reg_file[i] <= '0;
        end else if (we) begin
            reg_file[waddr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            div_rd_q  <= '0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (bad) begin
                            illegal_q <= 1'b1;
                        end else if (op == OP_DIV) begin
                            state_q  <= DIV_BUSY;
                            div_rd_q <= rd;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (div_done && !div_busy) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Operands are latched inside the divider, so rd may alias rs or rt.
    tinker_divider #(.DATA_W(DATA_W)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (op1),
        .divisor  (op2),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    assign in_ready = (state_q == IDLE);
    assign done     = done_q;
    assign illegal  = illegal_q;
    assign dbg_data = rf_read(dbg_addr);

endmodule

// File: tb/tb_tinker_seq_core.sv
// Self-checking bench for tinker_seq_core: in-order scoreboard of retire events,
// plus a 16-register instance for register-range rejection.
module tb_tinker_seq_core;

    localparam int W = 64;

    localparam int AND_ = 0,  OR_ = 1,  XOR_ = 2,  NOT_ = 3;
    localparam int SHR = 4,   SHRI = 5, SHL = 6,   SHLI = 7;
    localparam int MOV = 17,  MOVL = 18;
    localparam int ADD = 24,  ADDI = 25, SUB = 26, SUBI = 27, MUL = 28, DIV = 29;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, done, illegal;
    logic [31:0]  instruction;
    logic [4:0]   dbg_addr;
    logic [W-1:0] dbg_data;

    logic         in_valid16, in_ready16, done16, illegal16;
    logic [31:0]  instruction16;
    logic [4:0]   dbg_addr16;
    logic [W-1:0] dbg_data16;

    typedef struct packed {
        logic         ill;
        logic [4:0]   rd;
        logic [7:0]   lat;
        logic [31:0]  acc;
        logic [W-1:0] val;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] m_regs [32];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;

    tinker_seq_core #(.DATA_W(W), .NUM_REGS(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .done(done), .illegal(illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    tinker_seq_core #(.DATA_W(W), .NUM_REGS(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
        .instruction(instruction16), .done(done16), .illegal(illegal16),
        .dbg_addr(dbg_addr16), .dbg_data(dbg_data16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int op, input int rd, input int rs, input int rt, input int l);
        return {op[4:0], rd[4:0], rs[4:0], rt[4:0], l[11:0]};
    endfunction

    function automatic logic [W-1:0] model_alu(input logic [4:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        case (op)
            5'd0:         return a & b;
            5'd1:         return a | b;
            5'd2:         return a ^ b;
            5'd3:         return ~a;
            5'd4, 5'd5:   return a >> b[5:0];
            5'd6, 5'd7:   return a << b[5:0];
            5'd17:        return a;
            5'd18:        return b;
            5'd24, 5'd25: return a + b;
            5'd26, 5'd27: return a - b;
            5'd28:        return a * b;
            5'd29:        return (b == 0) ? {W{1'b1}} : a / b;
            default:      return '0;
        endcase
    endfunction

    function automatic logic model_legal(input logic [4:0] op);
        return (op <= 5'd7) || (op == 5'd17) || (op == 5'd18) || (op >= 5'd24 && op <= 5'd29);
    endfunction

    // Drive one instruction on the main core, hold it until accepted, and queue the expected retire.
    task automatic send(input logic [31:0] ins, output int acc);
        exp_t         e;
        int           n;
        logic [4:0]   op, rd, rs, rt;
        logic [W-1:0] a, b, lit;
        logic         imm;
        @(negedge clk);
        in_valid    = 1'b1;
        instruction = ins;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_eq("ready_timeout", {63'd0, in_ready}, 64'd1);
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        op  = ins[31:27];
        rd  = ins[26:22];
        rs  = ins[21:17];
        rt  = ins[16:12];
        lit = {{(W-12){ins[11]}}, ins[11:0]};
        imm = (op == 5'd5) || (op == 5'd7) || (op == 5'd25) || (op == 5'd27);
        a   = imm ? m_regs[rd] : m_regs[rs];
        b   = (imm || op == 5'd18) ? lit : m_regs[rt];
        e.rd  = rd;
        e.acc = acc;
        if (model_legal(op)) begin
            e.ill      = 1'b0;
            e.val      = model_alu(op, a, b);
            e.lat      = (op == 5'd29) ? 8'd65 : 8'd1;
            m_regs[rd] = e.val;
        end else begin
            e.ill = 1'b1;
            e.val = m_regs[rd];
            e.lat = 8'd1;
        end
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic count_stall(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_eq(tag, 64'(n), 64'd64);
    endtask

    // Every retire pulse is matched against the oldest outstanding instruction.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (done || illegal)) begin
            check_eq("done_illegal_excl", {63'd0, done && illegal}, 64'd0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_retire", {62'd0, done, illegal}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("retire_done", {63'd0, done}, {63'd0, !e.ill});
                check_eq("retire_illegal", {63'd0, illegal}, {63'd0, e.ill});
                check_eq("retire_latency", 64'(cyc) - 64'(e.acc), 64'(e.lat));
                dbg_addr = e.rd;
                #1;
                check_eq("reg_value", dbg_data, e.val);
            end
        end
    end

    initial begin
        int a1, a2, acc, n;
        int ops[15] = '{AND_, OR_, XOR_, NOT_, SHR, SHRI, SHL, SHLI, MOV, MOVL, ADD, ADDI, SUB, SUBI, MUL};

        reset = 1'b1;
        in_valid = 1'b0;   instruction = '0;   dbg_addr = '0;
        in_valid16 = 1'b0; instruction16 = '0; dbg_addr16 = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check_eq("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("reset_done", {63'd0, done}, 64'd0);
        check_eq("reset_illegal", {63'd0, illegal}, 64'd0);
        check_eq("reset_in_ready16", {63'd0, in_ready16}, 64'd1);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            check_eq("reset_reg", dbg_data, 64'd0);
        end

        // Sign-extended literal then immediate add wrapping through zero.
        send(enc(MOVL, 1, 0, 0, 12'hFFF), acc);
        send(enc(ADDI, 1, 0, 0, 2), acc);
        send(enc(MOVL, 2, 0, 0, 100), acc);
        send(enc(MOVL, 3, 0, 0, 7), acc);

        send(enc(DIV, 4, 2, 3, 0), acc);
        count_stall("div_stall");
        send(enc(DIV, 5, 2, 0, 0), acc);
        count_stall("div0_stall");

        send(enc(20, 1, 2, 3, 0), acc);
        send(enc(23, 2, 2, 3, 0), acc);

        send(enc(ADD, 7, 1, 1, 0), a1);
        send(enc(SHLI, 7, 0, 0, 4), a2);
        check_eq("b2b_no_bubble", 64'(a2 - a1), 64'd1);

        send(enc(DIV, 2, 2, 3, 0), acc);
        send(enc(SUBI, 8, 0, 0, 1), acc);
        send(enc(DIV, 9, 8, 3, 0), acc);

        for (int i = 10; i < 16; i++) send(enc(MOVL, i, 0, 0, $urandom_range(0, 4095)), acc);
        for (int k = 0; k < 30; k++) begin
            send(enc(ops[$urandom_range(0, 14)], $urandom_range(1, 15), $urandom_range(0, 15),
                     $urandom_range(0, 15), $urandom_range(0, 4095)), acc);
        end
        send(enc(MUL, 11, 10, 12, 0), acc);
        send(enc(SHR, 12, 11, 13, 0), acc);
        @(negedge clk);
        in_valid = 1'b0;

        // Register-range rejection on the 16-entry instance.
        @(negedge clk);
        in_valid16 = 1'b1;
        instruction16 = enc(ADD, 20, 1, 2, 0);
        @(negedge clk);
        instruction16 = enc(ADD, 1, 17, 2, 0);
        check_eq("r16_rd_illegal", {63'd0, illegal16}, 64'd1);
        check_eq("r16_rd_done", {63'd0, done16}, 64'd0);
        @(negedge clk);
        instruction16 = enc(MOVL, 3, 0, 0, 5);
        check_eq("r16_rs_illegal", {63'd0, illegal16}, 64'd1);
        @(negedge clk);
        in_valid16 = 1'b0;
        check_eq("r16_legal_done", {63'd0, done16}, 64'd1);
        check_eq("r16_legal_illegal", {63'd0, illegal16}, 64'd0);
        dbg_addr16 = 5'd3;
        #1;
        check_eq("r16_reg3", dbg_data16, 64'd5);
        dbg_addr16 = 5'd20;
        #1;
        check_eq("r16_dbg_oob", dbg_data16, 64'd0);

        // Reset in the middle of a divide: no retire, clean restart.
        send(enc(DIV, 6, 2, 3, 0), acc);
        repeat (10) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        check_eq("rst_div_in_ready", {63'd0, in_ready}, 64'd1);
        dbg_addr = 5'd6;
        #1;
        check_eq("rst_div_r6", dbg_data, 64'd0);
        n = 0;
        repeat (70) begin
            @(negedge clk);
            if (done) n++;
        end
        check_eq("rst_div_no_done", 64'(n), 64'd0);

        send(enc(MOVL, 9, 0, 0, 12'h123), acc);
        @(negedge clk);
        in_valid = 1'b0;

        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
